mem_port_arbiter: RTL and testbench

//  Shares the single-port Memory between instruction fetch (IF) and data access (DM).

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Round-robin on ties; each access holds the memory for 1+WAIT_STATES cycles.
module mem_port_arbiter #(
    parameter int WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_wen,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);
    typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_DM} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt;
    logic        last_dm;
    logic [31:0] addr_q, wdata_q;
    logic        wen_q;
    logic        done, decide, if_elig, dm_elig, grant;

    always_comb begin
        done    = (state_q != IDLE) && (wait_cnt == WS);
        decide  = (state_q == IDLE) || done;
        // The completing requester sits out one decision so its ack is seen first.
        if_elig = if_req && !(done && state_q == SERVE_IF);
        dm_elig = dm_req && !(done && state_q == SERVE_DM);
        state_d = state_q;
        if (decide) begin
            if (if_elig && dm_elig) state_d = last_dm ? SERVE_IF : SERVE_DM;
            else if (dm_elig)       state_d = SERVE_DM;
            else if (if_elig)       state_d = SERVE_IF;
            else                    state_d = IDLE;
        end
        grant = decide && (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wait_cnt <= '0;
            last_dm  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            mem_ren  <= 1'b0;
            mem_wen  <= 1'b0;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            state_q <= state_d;
            if_ack  <= done && (state_q == SERVE_IF);
            dm_ack  <= done && (state_q == SERVE_DM);
            if (done && state_q == SERVE_IF)           if_rdata <= mem_dout;
            if (done && state_q == SERVE_DM && !wen_q) dm_rdata <= mem_dout;

            // Memory strobes are flops so they cannot glitch on request changes.
            if (grant) begin
                wait_cnt <= '0;
                last_dm  <= (state_d == SERVE_DM);
                if (state_d == SERVE_DM) begin
                    addr_q  <= dm_addr;
                    wen_q   <= dm_wen;
                    wdata_q <= dm_wen ? dm_wdata : 32'h0;
                    mem_ren <= !dm_wen;
                    mem_wen <= dm_wen;
                end else begin
                    addr_q  <= if_addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    mem_ren <= 1'b1;
                    mem_wen <= 1'b0;
                end
            end else if (decide) begin
                addr_q  <= '0;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                mem_ren <= 1'b0;
                mem_wen <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    assign mem_addr = addr_q;
    assign mem_din  = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: WAIT_STATES=0 and WAIT_STATES=3 instances,
// each with its own negedge-write memory model.
module tb_mem_port_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        if_req0, if_ack0, dm_req0, dm_wen0, dm_ack0, mem_ren0, mem_wen0;
    logic [31:0] if_addr0, if_rdata0, dm_addr0, dm_wdata0, dm_rdata0, mem_addr0, mem_din0, mem_dout0;
    logic        if_req3, if_ack3, dm_req3, dm_wen3, dm_ack3, mem_ren3, mem_wen3;
    logic [31:0] if_addr3, if_rdata3, dm_addr3, dm_wdata3, dm_rdata3, mem_addr3, mem_din3, mem_dout3;

    mem_port_arbiter #(.WAIT_STATES(0)) u0 (
        .clock(clock), .reset(reset),
        .if_req(if_req0), .if_addr(if_addr0), .if_ack(if_ack0), .if_rdata(if_rdata0),
        .dm_req(dm_req0), .dm_wen(dm_wen0), .dm_addr(dm_addr0), .dm_wdata(dm_wdata0),
        .dm_ack(dm_ack0), .dm_rdata(dm_rdata0),
        .mem_ren(mem_ren0), .mem_wen(mem_wen0), .mem_addr(mem_addr0), .mem_din(mem_din0),
        .mem_dout(mem_dout0)
    );

    mem_port_arbiter #(.WAIT_STATES(3)) u3 (
        .clock(clock), .reset(reset),
        .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
        .dm_req(dm_req3), .dm_wen(dm_wen3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
        .dm_ack(dm_ack3), .dm_rdata(dm_rdata3),
        .mem_ren(mem_ren3), .mem_wen(mem_wen3), .mem_addr(mem_addr3), .mem_din(mem_din3),
        .mem_dout(mem_dout3)
    );

    logic [31:0] mem0 [64];
    logic [31:0] mem3 [64];
    assign mem_dout0 = mem0[mem_addr0[5:0]];
    assign mem_dout3 = mem3[mem_addr3[5:0]];
    always @(negedge clock) begin
        if (mem_wen0) mem0[mem_addr0[5:0]] = mem_din0;
        if (mem_wen3) mem3[mem_addr3[5:0]] = mem_din3;
    end

    logic [31:0] exp_if0[$];
    logic [31:0] exp_dm0[$];
    logic [31:0] exp_dm3[$];
    bit          order0[$];   // 1 = DM ack expected next, 0 = IF
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_strobes"}, 32'({if_ack0, dm_ack0, mem_ren0, mem_wen0}), 32'h0);
        chk({tag, "_if_rdata"}, if_rdata0, 32'h0);
        chk({tag, "_dm_rdata"}, dm_rdata0, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr0, 32'h0);
        chk({tag, "_mem_din"}, mem_din0, 32'h0);
    endtask

    // Monitor: pops the scoreboard whenever an ack appears.
    always @(negedge clock) begin
        if (reset) begin
            chk("ren_wen_excl0", 32'(mem_ren0 & mem_wen0), 32'h0);
            chk("ren_wen_excl3", 32'(mem_ren3 & mem_wen3), 32'h0);
            if (if_ack0) begin
                if (exp_if0.size() == 0) chk("if_ack0_unexpected", 32'(if_ack0), 32'h0);
                else chk("if_rdata0", if_rdata0, exp_if0.pop_front());
                if (order0.size() == 0) chk("order0_depth", 32'(order0.size()), 32'h1);
                else chk("order0_if", 32'(order0.pop_front()), 32'h0);
            end
            if (dm_ack0) begin
                if (exp_dm0.size() == 0) chk("dm_ack0_unexpected", 32'(dm_ack0), 32'h0);
                else chk("dm_rdata0", dm_rdata0, exp_dm0.pop_front());
                if (order0.size() == 0) chk("order0_depth", 32'(order0.size()), 32'h1);
                else chk("order0_dm", 32'(order0.pop_front()), 32'h1);
            end
            if (dm_ack3) begin
                if (exp_dm3.size() == 0) chk("dm_ack3_unexpected", 32'(dm_ack3), 32'h0);
                else chk("dm_rdata3", dm_rdata3, exp_dm3.pop_front());
            end
            if (if_ack3) chk("if_ack3_unexpected", 32'(if_ack3), 32'h0);
        end
    end

    task automatic if_access0(input logic [31:0] a);
        if_req0 = 1'b1;
        if_addr0 = a;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (if_ack0) break;
        end
        if (!if_ack0) chk("if0_ack_timeout", 32'(if_ack0), 32'h1);
        if_req0 = 1'b0;
    endtask

    task automatic dm_access0(input logic w, input logic [31:0] a, input logic [31:0] d);
        dm_req0 = 1'b1;
        dm_wen0 = w;
        dm_addr0 = a;
        dm_wdata0 = d;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (dm_ack0) break;
        end
        if (!dm_ack0) chk("dm0_ack_timeout", 32'(dm_ack0), 32'h1);
        dm_req0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, ndm, nif, rencnt;
        for (int i = 0; i < 64; i++) begin
            mem0[i] = {16'hC0DE, 16'(i)};
            mem3[i] = {16'hC0DE, 16'(i)};
        end
        mem0[8] = 32'h0000_1234;
        if_req0 = 0; if_addr0 = 0; dm_req0 = 0; dm_wen0 = 0; dm_addr0 = 0; dm_wdata0 = 0;
        if_req3 = 0; if_addr3 = 0; dm_req3 = 0; dm_wen3 = 0; dm_addr3 = 0; dm_wdata3 = 0;

        // Reset state
        repeat (2) @(negedge clock);
        chk_zero0("rst");
        @(posedge clock); #1;
        reset = 1'b1;

        // First tie after reset: DM store wins, IF follows; store leaves dm_rdata at 0
        exp_dm0.push_back(32'h0);
        exp_if0.push_back(32'h0000_1234);
        order0.push_back(1'b1);
        order0.push_back(1'b0);
        fork
            dm_access0(1'b1, 32'd4, 32'h0000_DEAD);
            if_access0(32'd8);
        join
        @(posedge clock); #1;
        chk("t3_mem4", mem0[4], 32'h0000_DEAD);

        // Single fetch latency with WAIT_STATES=0; req still high at completion edge
        exp_if0.push_back(32'h0000_1234);
        order0.push_back(1'b0);
        if_req0 = 1'b1;
        if_addr0 = 32'd8;
        @(posedge clock);
        @(negedge clock);
        chk("t2_ren_c0", 32'(mem_ren0), 32'h1);
        chk("t2_addr_c0", mem_addr0, 32'd8);
        chk("t2_ack_c0", 32'(if_ack0), 32'h0);
        @(negedge clock);
        chk("t2_ack_c1", 32'(if_ack0), 32'h1);
        chk("t2_ren_c1", 32'(mem_ren0), 32'h0);
        if_req0 = 1'b0;
        @(posedge clock); #1;

        // Both requests held: strict DM,IF alternation with no idle cycles
        for (int i = 0; i < 3; i++) begin
            exp_dm0.push_back(32'hC0DE_0010);
            exp_if0.push_back(32'hC0DE_0014);
            order0.push_back(1'b1);
            order0.push_back(1'b0);
        end
        dm_wen0 = 1'b0; dm_addr0 = 32'd16; if_addr0 = 32'd20;
        dm_req0 = 1'b1; if_req0 = 1'b1;
        cyc = 0; ndm = 0; nif = 0;
        while ((dm_req0 || if_req0) && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            if (dm_ack0) begin ndm++; if (ndm == 3) dm_req0 = 1'b0; end
            if (if_ack0) begin nif++; if (nif == 3) if_req0 = 1'b0; end
        end
        dm_req0 = 1'b0; if_req0 = 1'b0;
        chk("t4_cycles", 32'(cyc), 32'd7);

        // WAIT_STATES=3 load; address change mid-access ignored
        exp_dm3.push_back(32'hC0DE_000C);
        dm_wen3 = 1'b0; dm_addr3 = 32'd12; dm_req3 = 1'b1;
        cyc = 0; rencnt = 0;
        while (cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == 1) dm_addr3 = 32'd13;
            if (cyc == 2) chk("t5_addr_hold", mem_addr3, 32'd12);
            if (mem_ren3) rencnt++;
            if (dm_ack3) break;
        end
        dm_req3 = 1'b0;
        chk("t5_ren_cycles", 32'(rencnt), 32'd4);
        chk("t5_latency", 32'(cyc), 32'd5);

        // Reset during a store before its negedge: no write, no ack
        dm_wen0 = 1'b1; dm_addr0 = 32'd6; dm_wdata0 = 32'h0000_BEEF; dm_req0 = 1'b1;
        @(posedge clock); #1;
        chk("t6_wen_on", 32'(mem_wen0), 32'h1);
        #2 reset = 1'b0;
        #1 chk_zero0("t6_async");
        dm_req0 = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("t6_no_ack", 32'(dm_ack0), 32'h0);
        end
        chk("t6_mem6", mem0[6], 32'hC0DE_0006);

        // Tie after mid-run reset goes to DM again
        @(posedge clock); #1;
        exp_dm0.push_back(32'hC0DE_000A);
        exp_if0.push_back(32'hC0DE_0009);
        order0.push_back(1'b1);
        order0.push_back(1'b0);
        fork
            dm_access0(1'b0, 32'd10, 32'h0);
            if_access0(32'd9);
        join
        @(posedge clock); #1;
        chk("sb_drain", 32'(exp_if0.size() + exp_dm0.size() + exp_dm3.size() + order0.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
